// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: 2-flop sync, tick-driven FSM, press/release pulses.
// Define BTN_LONG_PRESS_EN to add the per-channel long-press pulse (o_btn_long).
module btn_debounce #(
   parameter int N_BTN      = 4,
   parameter int DEB_MS     = 20,
   parameter int LONG_MS    = 1000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_pls_1k,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_btn_lvl,
   output logic [N_BTN-1:0] o_btn_press,
   output logic [N_BTN-1:0] o_btn_release,
   output logic [N_BTN-1:0] o_btn_long
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } state_t;

   localparam logic [N_BTN-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [7:0]       DEB_LIM  = 8'(DEB_MS - 1);
   localparam bit               DEB_ONE  = (DEB_MS == 1);

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [N_BTN-1:0] w_s;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_sync1 <= IDLE_PIN;
         r_sync2 <= IDLE_PIN;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      state_t     r_state;
      state_t     w_state_nx;
      logic [7:0] r_deb;
      logic [7:0] w_deb_nx;
      logic       w_press_nx;
      logic       w_rel_nx;
      logic       r_press;
      logic       r_rel;
      logic       r_lvl;

      always_comb begin
         w_state_nx = r_state;
         w_deb_nx   = r_deb;
         w_press_nx = 1'b0;
         w_rel_nx   = 1'b0;
         if (i_pls_1k) begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_s[g]) begin
                     if (DEB_ONE) begin
                        w_state_nx = S_PRESSED;
                        w_press_nx = 1'b1;
                        w_deb_nx   = '0;
                     end else begin
                        w_state_nx = S_PRESS_WAIT;
                        w_deb_nx   = 8'd1;
                     end
                  end
               end
               S_PRESS_WAIT: begin
                  if (!w_s[g]) begin
                     w_state_nx = S_IDLE;
                     w_deb_nx   = '0;
                  end else if (r_deb == DEB_LIM) begin
                     w_state_nx = S_PRESSED;
                     w_press_nx = 1'b1;
                     w_deb_nx   = '0;
                  end else begin
                     w_deb_nx = r_deb + 8'd1;
                  end
               end
               S_PRESSED: begin
                  if (!w_s[g]) begin
                     if (DEB_ONE) begin
                        w_state_nx = S_IDLE;
                        w_rel_nx   = 1'b1;
                        w_deb_nx   = '0;
                     end else begin
                        w_state_nx = S_RELEASE_WAIT;
                        w_deb_nx   = 8'd1;
                     end
                  end
               end
               S_RELEASE_WAIT: begin
                  // a tick seeing the held level is a bounce: back to stable
                  if (w_s[g]) begin
                     w_state_nx = S_PRESSED;
                     w_deb_nx   = '0;
                  end else if (r_deb == DEB_LIM) begin
                     w_state_nx = S_IDLE;
                     w_rel_nx   = 1'b1;
                     w_deb_nx   = '0;
                  end else begin
                     w_deb_nx = r_deb + 8'd1;
                  end
               end
               default: begin
                  w_state_nx = S_IDLE;
                  w_deb_nx   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            r_state <= S_IDLE;
            r_deb   <= '0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_lvl   <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_deb   <= w_deb_nx;
            r_press <= w_press_nx;
            r_rel   <= w_rel_nx;
            r_lvl   <= (w_state_nx == S_PRESSED) ||
                       (w_state_nx == S_RELEASE_WAIT);
         end
      end

      assign o_btn_lvl[g]     = r_lvl;
      assign o_btn_press[g]   = r_press;
      assign o_btn_release[g] = r_rel;

`ifdef BTN_LONG_PRESS_EN
      localparam logic [15:0] LONG_LIM_M1 = 16'(LONG_MS - DEB_MS - 1);

      logic [15:0] r_long_cnt;
      logic [15:0] w_long_nx;
      logic        w_long_pls;
      logic        r_long;
      logic        w_held;

      assign w_held = (r_state == S_PRESSED) ||
                      (r_state == S_RELEASE_WAIT);

      // saturate at the threshold so only one pulse fires per press
      always_comb begin
         w_long_nx  = r_long_cnt;
         w_long_pls = 1'b0;
         if (i_pls_1k) begin
            if (w_state_nx == S_IDLE || w_press_nx) begin
               w_long_nx = '0;
            end else if (w_held && r_long_cnt <= LONG_LIM_M1) begin
               w_long_nx  = r_long_cnt + 16'd1;
               w_long_pls = (r_long_cnt == LONG_LIM_M1);
            end
         end
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
         end else begin
            r_long_cnt <= w_long_nx;
            r_long     <= w_long_pls;
         end
      end

      assign o_btn_long[g] = r_long;
`else
      assign o_btn_long[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized + directed bench for btn_debounce against a run-length reference model.
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_debounce;

   localparam int N_BTN      = 4;
   localparam int DEB_MS     = 20;
   localparam int LONG_MS    = 1000;
   localparam int ACTIVE_LOW = 1;
`ifdef BTN_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rstn;
   logic             i_pls_1k;
   logic [N_BTN-1:0] i_btn;
   logic [N_BTN-1:0] o_btn_lvl;
   logic [N_BTN-1:0] o_btn_press;
   logic [N_BTN-1:0] o_btn_release;
   logic [N_BTN-1:0] o_btn_long;

   btn_debounce #(
      .N_BTN     (N_BTN),
      .DEB_MS    (DEB_MS),
      .LONG_MS   (LONG_MS),
      .ACTIVE_LOW(ACTIVE_LOW)
   ) u_dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_pls_1k     (i_pls_1k),
      .i_btn        (i_btn),
      .o_btn_lvl    (o_btn_lvl),
      .o_btn_press  (o_btn_press),
      .o_btn_release(o_btn_release),
      .o_btn_long   (o_btn_long)
   );

   always #20 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [N_BTN-1:0] m_lvl;
   logic [N_BTN-1:0] exp_press;
   logic [N_BTN-1:0] exp_rel;
   logic [N_BTN-1:0] exp_long;
   int               m_run [N_BTN];
   int               m_held[N_BTN];
   int               cnt_press[N_BTN];
   int               cnt_long [N_BTN];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lvl     = '0;
      exp_press = '0;
      exp_rel   = '0;
      exp_long  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         m_run[i]  = 0;
         m_held[i] = 0;
      end
   endtask

   // Accept a level after DEB_MS consecutive ticks disagreeing with it.
   task automatic model_tick();
      logic s;
      exp_press = '0;
      exp_rel   = '0;
      exp_long  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         s = (ACTIVE_LOW != 0) ? ~i_btn[i] : i_btn[i];
         if (s != m_lvl[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == DEB_MS) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
               exp_press[i] = 1'b1;
               m_held[i]    = 0;
            end else begin
               exp_rel[i] = 1'b1;
            end
         end else if (m_lvl[i]) begin
            m_held[i]++;
            if (LONG_EN && m_held[i] == LONG_MS - DEB_MS)
               exp_long[i] = 1'b1;
         end
      end
   endtask

   task automatic cyc(input logic [N_BTN-1:0] pins, input logic tk);
      @(negedge i_clk);
      check("lvl",     32'(o_btn_lvl),     32'(m_lvl));
      check("press",   32'(o_btn_press),   32'(exp_press));
      check("release", 32'(o_btn_release), 32'(exp_rel));
      check("long",    32'(o_btn_long),    32'(exp_long));
      check("excl",    32'(o_btn_press & o_btn_release), 32'd0);
      for (int i = 0; i < N_BTN; i++) begin
         cnt_press[i] += int'(o_btn_press[i]);
         cnt_long[i]  += int'(o_btn_long[i]);
      end
      i_btn    = pins;
      i_pls_1k = tk;
      if (tk && i_rstn) begin
         model_tick();
      end else begin
         exp_press = '0;
         exp_rel   = '0;
         exp_long  = '0;
      end
   endtask

   task automatic run_ticks(input logic [N_BTN-1:0] pins, input int n);
      for (int k = 0; k < n; k++) begin
         cyc(pins, 1'b0);
         cyc(pins, 1'b0);
         cyc(pins, 1'b0);
         cyc(pins, 1'b1);
      end
   endtask

   task automatic clr_counts();
      for (int i = 0; i < N_BTN; i++) begin
         cnt_press[i] = 0;
         cnt_long[i]  = 0;
      end
   endtask

   initial begin
      logic [N_BTN-1:0] pins;
      int               w;
      i_rstn   = 1'b0;
      i_pls_1k = 1'b0;
      i_btn    = '1;
      model_reset();
      clr_counts();

      run_ticks(4'hF, 100);
      check("rst_press_cnt", 32'(cnt_press[0] + cnt_press[1] +
                                 cnt_press[2] + cnt_press[3]), 32'd0);
      i_rstn = 1'b1;
      run_ticks(4'hF, 5);

      clr_counts();
      run_ticks(4'b1110, 30);
      check("ch0_press_cnt", 32'(cnt_press[0]), 32'd1);
      check("ch0_lvl", 32'(o_btn_lvl), 32'h1);

      clr_counts();
      run_ticks(4'b1100, 5);
      run_ticks(4'b1110, 1);
      run_ticks(4'b1100, 19);
      check("ch1_early", 32'(cnt_press[1]), 32'd0);
      run_ticks(4'b1100, 6);
      check("ch1_press_cnt", 32'(cnt_press[1]), 32'd1);

      clr_counts();
      run_ticks(4'b1101, 21);
      check("ch0_rel_lvl", 32'(o_btn_lvl[0]), 32'd0);
      check("ch0_no_press", 32'(cnt_press[0]), 32'd0);

      clr_counts();
      run_ticks(4'b1011, 1500);
      check("ch2_press_cnt", 32'(cnt_press[2]), 32'd1);
      check("ch2_long_cnt", 32'(cnt_long[2]), LONG_EN ? 32'd1 : 32'd0);
      run_ticks(4'hF, 25);

      clr_counts();
      run_ticks(4'b0111, 25);
      check("ch3_lvl", 32'(o_btn_lvl[3]), 32'd1);
      @(negedge i_clk);
      #5 i_rstn = 1'b0;
      #1;
      check("arst_lvl", 32'(o_btn_lvl), 32'd0);
      check("arst_rel", 32'(o_btn_release), 32'd0);
      check("arst_press", 32'(o_btn_press), 32'd0);
      model_reset();
      cyc(4'b0111, 1'b0);
      cyc(4'b0111, 1'b1);
      cyc(4'b0111, 1'b0);
      i_rstn = 1'b1;
      clr_counts();
      run_ticks(4'b0111, 19);
      check("ch3_re_early", 32'(cnt_press[3]), 32'd0);
      run_ticks(4'b0111, 6);
      check("ch3_re_press", 32'(cnt_press[3]), 32'd1);

      pins = 4'b0111;
      for (int t = 0; t < 2000; t++) begin
         for (int i = 0; i < N_BTN; i++)
            if ($urandom_range(0, 39) == 0) pins[i] = ~pins[i];
         w = ($urandom_range(0, 7) == 0) ? 2 : 1;
         cyc(pins, 1'b0);
         cyc(pins, 1'b0);
         cyc(pins, 1'b0);
         for (int k = 0; k < w; k++) cyc(pins, 1'b1);
      end
      cyc(pins, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
